voice_lookup_sched: RTL and testbench

- Time-multiplexes one shared phase-to-sample lookup (7-bit phase, 7-bit program in; 8-bit unsigned sample out; fixed pipeline latency) across NUM_VOICES oscillator voices.
- On each sample-rate tick it snapshots every voice's phase and program, then issues one lookup per cycle.
- It captures the returned samples into per-voice output registers and signals frame completion.
- Sits between the per-voice phase accumulators and the voice mixer/DAC path.

---
 rtl/voice_lookup_sched_pkg.sv | 20 ++
 rtl/voice_lookup_sched_if.sv | 25 ++
 rtl/voice_lookup_sched_lookup_lat_pipe.sv | 53 +++++
 rtl/voice_lookup_sched.sv | 231 +++++++++++++++++++++++
 tb/tb_voice_lookup_sched.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/voice_lookup_sched_pkg.sv
// Shared definitions for the voice lookup scheduler: datapath widths,
// the midscale sample value and the frame sequencer state encoding.
package vsynth_pkg;

   localparam int SAMPLE_W = 8;
   localparam int PHASE_W  = 7;
   localparam int PROG_W   = 7;

   // Unsigned midscale, the "silent" value of an 8-bit unsigned sample.
   localparam logic [SAMPLE_W-1:0] SAMPLE_MID = 8'd128;

   // Frame sequencer states. Plain vector constants keep the encoding
   // visible to older tools and netlist viewers.
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ISSUE = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/voice_lookup_sched_if.sv
// Bus between the scheduler (master) and the shared phase-to-sample
// lookup (slave). The lookup registers advance only while lk_ce is high.
interface voice_lookup_sched_if;
   import vsynth_pkg::*;

   logic                lk_ce;
   logic [PHASE_W-1:0]  lk_phase;
   logic [PROG_W-1:0]   lk_program;
   logic [SAMPLE_W-1:0] lk_sample;

   modport master (
      output lk_ce,
      output lk_phase,
      output lk_program,
      input  lk_sample
   );

   modport slave (
      input  lk_ce,
      input  lk_phase,
      input  lk_program,
      output lk_sample
   );

endinterface

// File: rtl/voice_lookup_sched_lookup_lat_pipe.sv
// Tracks which voice each in-flight lookup belongs to. A LAT-deep shift
// register of {valid, voice index} that advances in lockstep with the
// shared lookup (same clock enable), so its output lines up with lk_sample.
module lookup_lat_pipe #(
   parameter int LAT   = 2,
   parameter int IDX_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             in_valid,
   input  logic [IDX_W-1:0] in_idx,
   output logic             out_valid,
   output logic [IDX_W-1:0] out_idx
);

   logic [LAT-1:0]   valid_q, valid_d;
   logic [IDX_W-1:0] idx_q [LAT];
   logic [IDX_W-1:0] idx_d [LAT];

   // Next-state: shift one stage per enabled cycle, otherwise hold.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path leaves it unassigned and no latch is inferred.
      valid_d = valid_q;
      idx_d   = idx_q;
      if (ce) begin
         valid_d[0] = in_valid;
         idx_d[0]   = in_idx;
         for (int i = 1; i < LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            idx_d[i]   = idx_q[i-1];
         end
      end
   end

   // Stage registers; reset empties the pipe so no stale capture survives.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < LAT; i++) idx_q[i] <= '0;
      end else begin
         valid_q <= valid_d;
         idx_q   <= idx_d;
      end
   end

   assign out_valid = valid_q[LAT-1];
   assign out_idx   = idx_q[LAT-1];

endmodule

// File: rtl/voice_lookup_sched.sv
// Time-multiplexes one shared phase-to-sample lookup across NUM_VOICES
// voices. Each tick snapshots all voices, issues one lookup per cycle,
// drains the lookup pipeline and captures results into per-voice registers.
// Optional build macro VOICE_SCHED_MIX_EN adds mix_out, the frame sum of the
// gated voices' samples, presented together with frame_valid.
module voice_lookup_sched
   import vsynth_pkg::*;
#(
   parameter int NUM_VOICES = 8,
   parameter int LOOKUP_LAT = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           tick,
   input  logic [NUM_VOICES*PHASE_W-1:0]  voice_phase,
   input  logic [NUM_VOICES*PROG_W-1:0]   voice_program,
   input  logic [NUM_VOICES-1:0]          voice_gate,
   voice_lookup_sched_if.master           lk,
   output logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
   output logic                           frame_valid,
   output logic                           busy,
   output logic                           overrun
`ifdef VOICE_SCHED_MIX_EN
   ,
   output logic [SAMPLE_W+$clog2(NUM_VOICES)-1:0] mix_out
`endif
);

   localparam int IDX_W = $clog2(NUM_VOICES);
   localparam int CNT_W = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_VOICES - 1);
   localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(LOOKUP_LAT - 1);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    issue_idx_q, issue_idx_d;
   logic [CNT_W-1:0]    drain_cnt_q, drain_cnt_d;
   logic                lk_ce_q, lk_ce_d;
   logic [PHASE_W-1:0]  lk_phase_q, lk_phase_d;
   logic [PROG_W-1:0]   lk_program_q, lk_program_d;
   logic                frame_valid_q, frame_valid_d;
   logic                busy_q, busy_d;
   logic                overrun_q, overrun_d;

   logic [PHASE_W-1:0]  snap_phase_q [NUM_VOICES];
   logic [PHASE_W-1:0]  snap_phase_d [NUM_VOICES];
   logic [PROG_W-1:0]   snap_prog_q  [NUM_VOICES];
   logic [PROG_W-1:0]   snap_prog_d  [NUM_VOICES];
   logic [NUM_VOICES-1:0] snap_gate_q, snap_gate_d;

   logic [SAMPLE_W-1:0] sample_q [NUM_VOICES];
   logic [SAMPLE_W-1:0] sample_d [NUM_VOICES];

   logic                cap_valid;
   logic [IDX_W-1:0]    cap_idx;
   logic                cap_en;

   // Frame sequencer: snapshot on tick, issue, drain, announce completion.
   always_comb begin
      state_d       = state_q;
      issue_idx_d   = issue_idx_q;
      drain_cnt_d   = drain_cnt_q;
      snap_phase_d  = snap_phase_q;
      snap_prog_d   = snap_prog_q;
      snap_gate_d   = snap_gate_q;
      lk_ce_d       = lk_ce_q;
      lk_phase_d    = lk_phase_q;
      lk_program_d  = lk_program_q;
      frame_valid_d = 1'b0;
      // Any tick that cannot be accepted is remembered until reset.
      overrun_d     = overrun_q | (tick & (state_q != ST_IDLE));

      case (state_q)
         ST_IDLE: begin
            if (tick) begin
               state_d     = ST_ISSUE;
               issue_idx_d = '0;
               for (int v = 0; v < NUM_VOICES; v++) begin
                  snap_phase_d[v] = voice_phase[v*PHASE_W +: PHASE_W];
                  snap_prog_d[v]  = voice_program[v*PROG_W +: PROG_W];
               end
               snap_gate_d  = voice_gate;
               // Voice 0 goes on the bus in the first ISSUE cycle, straight
               // from the inputs being snapshotted at this same edge.
               lk_ce_d      = 1'b1;
               lk_phase_d   = voice_phase[PHASE_W-1:0];
               lk_program_d = voice_program[PROG_W-1:0];
            end
         end
         ST_ISSUE: begin
            if (issue_idx_q == LAST_IDX) begin
               state_d     = ST_DRAIN;
               drain_cnt_d = '0;
            end else begin
               issue_idx_d  = issue_idx_q + IDX_W'(1);
               lk_phase_d   = snap_phase_q[issue_idx_d];
               lk_program_d = snap_prog_q[issue_idx_d];
            end
         end
         ST_DRAIN: begin
            if (drain_cnt_q == LAST_DRAIN) begin
               state_d       = ST_DONE;
               lk_ce_d       = 1'b0;
               frame_valid_d = 1'b1;
            end else begin
               drain_cnt_d = drain_cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // Control registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         issue_idx_q   <= '0;
         drain_cnt_q   <= '0;
         lk_ce_q       <= 1'b0;
         lk_phase_q    <= '0;
         lk_program_q  <= '0;
         frame_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         issue_idx_q   <= issue_idx_d;
         drain_cnt_q   <= drain_cnt_d;
         lk_ce_q       <= lk_ce_d;
         lk_phase_q    <= lk_phase_d;
         lk_program_q  <= lk_program_d;
         frame_valid_q <= frame_valid_d;
         busy_q        <= busy_d;
         overrun_q     <= overrun_d;
      end
   end

   // Snapshot registers: only read after a tick has loaded them.
   always_ff @(posedge clk) begin
      snap_phase_q <= snap_phase_d;
      snap_prog_q  <= snap_prog_d;
      snap_gate_q  <= snap_gate_d;
   end

   // Voice tag of the lookup result currently on lk_sample.
   lookup_lat_pipe #(
      .LAT   (LOOKUP_LAT),
      .IDX_W (IDX_W)
   ) u_lat_pipe (
      .clk       (clk),
      .rst       (rst),
      .ce        (lk_ce_q),
      .in_valid  (state_q == ST_ISSUE),
      .in_idx    (issue_idx_q),
      .out_valid (cap_valid),
      .out_idx   (cap_idx)
   );

   assign cap_en = cap_valid & lk_ce_q;

   // Capture: write the tagged voice, forcing midscale for gated-off voices.
   always_comb begin
      sample_d = sample_q;
      if (cap_en) begin
         sample_d[cap_idx] = snap_gate_q[cap_idx] ? lk.lk_sample : SAMPLE_MID;
      end
   end

   // Per-voice output registers.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: this array is reset (unlike the snapshot) because downstream
      // logic reads it immediately and must see midscale, not stale data.
      if (rst) begin
         for (int v = 0; v < NUM_VOICES; v++) sample_q[v] <= SAMPLE_MID;
      end else begin
         sample_q <= sample_d;
      end
   end

`ifdef VOICE_SCHED_MIX_EN
   localparam int MIX_W = SAMPLE_W + $clog2(NUM_VOICES);

   logic [MIX_W-1:0] acc_q, acc_d;
   logic [MIX_W-1:0] mix_q, mix_d;

   // Frame sum: clear on tick acceptance, add gated captures, publish at DONE.
   always_comb begin
      acc_d = acc_q;
      mix_d = mix_q;
      if ((state_q == ST_IDLE) && tick) begin
         acc_d = '0;
      end else if (cap_en && snap_gate_q[cap_idx]) begin
         acc_d = acc_q + MIX_W'(lk.lk_sample);
      end
      if (frame_valid_d) begin
         mix_d = acc_d;
      end
   end

   // Accumulator and published mix registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         mix_q <= '0;
      end else begin
         acc_q <= acc_d;
         mix_q <= mix_d;
      end
   end

   assign mix_out = mix_q;
`endif

   assign lk.lk_ce      = lk_ce_q;
   assign lk.lk_phase   = lk_phase_q;
   assign lk.lk_program = lk_program_q;
   assign frame_valid   = frame_valid_q;
   assign busy          = busy_q;
   assign overrun       = overrun_q;

   for (genvar v = 0; v < NUM_VOICES; v++) begin : g_pack
      assign voice_sample[v*SAMPLE_W +: SAMPLE_W] = sample_q[v];
   end

endmodule

// File: tb/tb_voice_lookup_sched.sv
// Self-checking bench for voice_lookup_sched. Contains a behavioural
// stand-in for the shared lookup and a frame-level reference model.
module tb_voice_lookup_sched;
   import vsynth_pkg::*;

   localparam int N = 8;
   localparam int L = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic           tick;
   logic [N*7-1:0] voice_phase;
   logic [N*7-1:0] voice_program;
   logic [N-1:0]   voice_gate;
   logic [N*8-1:0] voice_sample;
   logic           frame_valid;
   logic           busy;
   logic           overrun;
`ifdef VOICE_SCHED_MIX_EN
   logic [10:0]    mix_out;
`endif

   voice_lookup_sched_if lk ();

   voice_lookup_sched #(
      .NUM_VOICES (N),
      .LOOKUP_LAT (L)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .tick          (tick),
      .voice_phase   (voice_phase),
      .voice_program (voice_program),
      .voice_gate    (voice_gate),
      .lk            (lk),
      .voice_sample  (voice_sample),
      .frame_valid   (frame_valid),
      .busy          (busy),
      .overrun       (overrun)
`ifdef VOICE_SCHED_MIX_EN
      ,
      .mix_out       (mix_out)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Lookup stand-in: mode 0 -> phase*2, 1 -> 255, 2 -> phase+program.
   int lk_mode = 0;

   function automatic logic [7:0] lk_fn(input int mode, input logic [6:0] ph,
                                        input logic [6:0] pr);
      case (mode)
         0:       return {ph, 1'b0};
         1:       return 8'hFF;
         default: return {1'b0, ph} + {1'b0, pr};
      endcase
   endfunction

   logic [7:0] lk_pipe [L];
   initial for (int i = 0; i < L; i++) lk_pipe[i] = 8'd0;
   always @(posedge clk) begin
      if (lk.lk_ce) begin
         lk_pipe[0] <= lk_fn(lk_mode, lk.lk_phase, lk.lk_program);
         for (int i = 1; i < L; i++) lk_pipe[i] <= lk_pipe[i-1];
      end
   end
   assign lk.lk_sample = lk_pipe[L-1];

   // Counters and checker.
   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input int idx, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d] at cycle %0d: got %0d, want %0d", name, idx, cyc, act, exp);
      end
   endtask

   // Frame-level reference model.
   bit         m_active = 1'b0;
   int         m_t = 0;
   logic [6:0] m_ph [N];
   logic [6:0] m_pr [N];
   logic [7:0] m_frame [N];
   logic [7:0] m_samp [N];
   int         m_sum = 0;
   int         m_mix = 0;
   bit         m_ovr = 1'b0;
   bit         e_busy, e_fv, e_ce;
   int         fv_count = 0;
   int         fv_cyc = 0;
   int         tick_cyc = 0;
   int         mix_at_fv = 0;

   initial for (int v = 0; v < N; v++) m_samp[v] = 8'd128;

   always @(negedge clk) begin
      if (rst) begin
         m_active = 1'b0;
         m_ovr    = 1'b0;
         m_mix    = 0;
         for (int v = 0; v < N; v++) m_samp[v] = 8'd128;
      end else begin
         // Voice v is issued at t+1+v, returns at t+1+v+L, visible next cycle.
         for (int v = 0; v < N; v++)
            if (m_active && cyc == m_t + v + L + 2) m_samp[v] = m_frame[v];
      end

      e_busy = m_active && (cyc >= m_t + 1) && (cyc <= m_t + N + L + 1);
      e_fv   = m_active && (cyc == m_t + N + L + 1);
      e_ce   = m_active && (cyc >= m_t + 1) && (cyc <= m_t + N + L);
      if (e_fv) m_mix = m_sum;

      check("frame_valid", 0, 32'(frame_valid), 32'(e_fv));
      check("busy", 0, 32'(busy), 32'(e_busy));
      check("overrun", 0, 32'(overrun), 32'(m_ovr));
      check("lk_ce", 0, 32'(lk.lk_ce), 32'(e_ce));
      for (int v = 0; v < N; v++)
         check("voice_sample", v, 32'(voice_sample[v*8 +: 8]), 32'(m_samp[v]));
      if (e_ce && cyc <= m_t + N) begin
         check("lk_phase", cyc - m_t - 1, 32'(lk.lk_phase), 32'(m_ph[cyc - m_t - 1]));
         check("lk_program", cyc - m_t - 1, 32'(lk.lk_program), 32'(m_pr[cyc - m_t - 1]));
      end
`ifdef VOICE_SCHED_MIX_EN
      check("mix_out", 0, 32'(mix_out), m_mix);
`endif

      if (frame_valid === 1'b1) begin
         fv_count++;
         fv_cyc = cyc;
`ifdef VOICE_SCHED_MIX_EN
         mix_at_fv = 32'(mix_out);
`endif
      end

      if (!rst) begin
         if (e_fv) m_active = 1'b0;
         if (tick) begin
            if (e_busy) begin
               m_ovr = 1'b1;
            end else begin
               m_active = 1'b1;
               m_t      = cyc;
               tick_cyc = cyc;
               m_sum    = 0;
               for (int v = 0; v < N; v++) begin
                  m_ph[v] = voice_phase[v*7 +: 7];
                  m_pr[v] = voice_program[v*7 +: 7];
                  m_frame[v] = voice_gate[v] ? lk_fn(lk_mode, m_ph[v], m_pr[v]) : 8'd128;
                  if (voice_gate[v]) m_sum += 32'(m_frame[v]);
               end
            end
         end
      end
   end

   // Stimulus helpers: inputs change 1 time unit after the rising edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_tick();
      tick = 1'b1;
      step(1);
      tick = 1'b0;
   endtask

   task automatic set_voice(input int v, input int ph, input int pr);
      voice_phase[v*7 +: 7]   = 7'(ph);
      voice_program[v*7 +: 7] = 7'(pr);
   endtask

   int fv_before;

   initial begin
      rst = 1'b1;
      tick = 1'b0;
      voice_phase = '0;
      voice_program = '0;
      voice_gate = '0;
      step(3);
      rst = 1'b0;
      step(2);

      // Reset three cycles into a frame discards it.
      for (int v = 0; v < N; v++) set_voice(v, v, 0);
      voice_gate = '1;
      pulse_tick();
      step(2);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(1);
      check("rst_busy", 0, 32'(busy), 0);
      for (int v = 0; v < N; v++) check("rst_sample", v, 32'(voice_sample[v*8 +: 8]), 128);
      step(12);
      check("rst_no_frame", 0, fv_count, 0);

      // Clean frame, lookup = phase*2.
      pulse_tick();
      step(14);
      check("frame_count", 0, fv_count, 1);
      check("fv_latency", 0, fv_cyc - tick_cyc, 11);
      for (int v = 0; v < N; v++) check("ramp_sample", v, 32'(voice_sample[v*8 +: 8]), 2 * v);

      // Alternate gating.
      for (int v = 0; v < N; v++) set_voice(v, 10, 0);
      voice_gate = 8'b1010_1010;
      pulse_tick();
      step(14);
      for (int v = 0; v < N; v++)
         check("gate_sample", v, 32'(voice_sample[v*8 +: 8]), (v % 2 == 1) ? 20 : 128);

      // Inputs scrambled every cycle after the tick; program passes through.
      lk_mode = 2;
      voice_gate = '1;
      for (int v = 0; v < N; v++) set_voice(v, 3 * v, v);
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      for (int c = 0; c < 13; c++) begin
         for (int v = 0; v < N; v++)
            set_voice(v, $urandom_range(0, 127), $urandom_range(0, 127));
         voice_gate = 8'($urandom_range(0, 255));
         step(1);
      end
      for (int v = 0; v < N; v++) check("snap_sample", v, 32'(voice_sample[v*8 +: 8]), 4 * v);

      // Second tick four cycles after the first is an overrun.
      lk_mode = 0;
      voice_gate = '1;
      for (int v = 0; v < N; v++) set_voice(v, v + 1, 0);
      fv_before = fv_count;
      pulse_tick();
      step(3);
      pulse_tick();
      step(14);
      check("overrun_set", 0, 32'(overrun), 1);
      check("overrun_frames", 0, fv_count - fv_before, 1);
      check("overrun_idle", 0, 32'(busy), 0);
      for (int v = 0; v < N; v++) check("ovr_sample", v, 32'(voice_sample[v*8 +: 8]), 2 * (v + 1));
      step(5);
      check("overrun_sticky", 0, 32'(overrun), 1);

`ifdef VOICE_SCHED_MIX_EN
      // Full-scale mix.
      lk_mode = 1;
      voice_gate = '1;
      pulse_tick();
      step(14);
      check("mix_full", 0, mix_at_fv, 2040);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
